// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, funct codes,
// ALU class and ALU operation codes, plus the pure decode helper functions.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT = 4'b0111;
    localparam logic [3:0] ALUCTL_NOR = 4'b1100;

    typedef struct packed {
        logic       regdst;
        logic       branch_eq;
        logic       branch_ne;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    // Unknown opcodes decode to an all-zero bundle (a harmless no-op add).
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.aluop = ALUOP_FUNCT; end
            OP_LW:    begin c.memread = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_SW:    begin c.memwrite = 1'b1; c.alusrc = 1'b1; end
            OP_ADDI:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_BEQ:   begin c.branch_eq = 1'b1; c.aluop = ALUOP_SUB; end
            OP_BNE:   begin c.branch_ne = 1'b1; c.aluop = ALUOP_SUB; end
            OP_J:     c.jump = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] alu_control(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] ctl;
        ctl = ALUCTL_ADD;
        case (aluop)
            ALUOP_SUB:   ctl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  ctl = ALUCTL_SUB;
                    FN_AND:  ctl = ALUCTL_AND;
                    FN_OR:   ctl = ALUCTL_OR;
                    FN_NOR:  ctl = ALUCTL_NOR;
                    FN_SLT:  ctl = ALUCTL_SLT;
                    default: ctl = ALUCTL_ADD;
                endcase
            end
            default:     ctl = ALUCTL_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mips_alu_core.sv
// Combinational MIPS ALU: and/or/add/sub/nor/slt selected by a 4-bit control.
module mips_alu_core
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        ctl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out,
    output logic              zero
);

    logic slt_bit;

    assign slt_bit = ($signed(a) < $signed(b));

    always_comb begin
        out = '0;
        case (ctl)
            ALUCTL_AND: out = a & b;
            ALUCTL_OR:  out = a | b;
            ALUCTL_ADD: out = a + b;
            ALUCTL_SUB: out = a - b;
            ALUCTL_NOR: out = ~(a | b);
            ALUCTL_SLT: out = {{(DATA_W-1){1'b0}}, slt_bit};
            default:    out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/mips_decode_exec.sv
// Single-stage decode + execute: control decode, ALU control and ALU are
// combinational, and everything lands in one output register.
module mips_decode_exec
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [5:0]        opcode,
    input  logic [15:0]       imm,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    output logic              regdst,
    output logic              branch_eq,
    output logic              branch_ne,
    output logic              memread,
    output logic              memwrite,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrc,
    output logic              jump,
    output logic [1:0]        aluop,
    output logic [3:0]        aluctl,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Valid-only handshake with no backpressure: each cycle with in_valid=1
    // yields exactly one out_valid=1 cycle one clock later; while in_valid=0
    // the data outputs keep their last values.

    ctrl_t             ctrl_d;
    logic [3:0]        aluctl_d;
    logic [DATA_W-1:0] opb_d;
    logic [DATA_W-1:0] result_d;
    logic              zero_d;

    always_comb begin
        ctrl_d   = decode_ctrl(opcode);
        aluctl_d = alu_control(ctrl_d.aluop, imm[5:0]);
        opb_d    = ctrl_d.alusrc ? {{(DATA_W-16){imm[15]}}, imm} : b;
    end

    mips_alu_core #(.DATA_W(DATA_W)) u_alu (
        .ctl  (aluctl_d),
        .a    (a),
        .b    (opb_d),
        .out  (result_d),
        .zero (zero_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            regdst    <= 1'b0;
            branch_eq <= 1'b0;
            branch_ne <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            memtoreg  <= 1'b0;
            regwrite  <= 1'b0;
            alusrc    <= 1'b0;
            jump      <= 1'b0;
            aluop     <= 2'b00;
            aluctl    <= 4'b0000;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                regdst    <= ctrl_d.regdst;
                branch_eq <= ctrl_d.branch_eq;
                branch_ne <= ctrl_d.branch_ne;
                memread   <= ctrl_d.memread;
                memwrite  <= ctrl_d.memwrite;
                memtoreg  <= ctrl_d.memtoreg;
                regwrite  <= ctrl_d.regwrite;
                alusrc    <= ctrl_d.alusrc;
                jump      <= ctrl_d.jump;
                aluop     <= ctrl_d.aluop;
                aluctl    <= aluctl_d;
                result    <= result_d;
                zero      <= zero_d;
            end
        end
    end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed, table-driven bench for mips_decode_exec with hand-computed
// expectations and a few reset / hold sequences.
module tb_mips_decode_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [5:0]    opcode;
    logic [15:0]   imm;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump;
    logic [1:0]    aluop;
    logic [3:0]    aluctl;
    logic [W-1:0]  result;
    logic          zero;

    int total = 0;
    int bad   = 0;

    // ctl order: regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump
    typedef struct {
        string       name;
        logic [5:0]  opcode;
        logic [15:0] imm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [8:0]  ctl;
        logic [1:0]  aluop;
        logic [3:0]  aluctl;
        logic [W-1:0] result;
        logic        zero;
    } vec_t;

    vec_t vecs[16];

    mips_decode_exec #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .imm       (imm),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .regdst    (regdst),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .memread   (memread),
        .memwrite  (memwrite),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrc    (alusrc),
        .jump      (jump),
        .aluop     (aluop),
        .aluctl    (aluctl),
        .result    (result),
        .zero      (zero)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [8:0] dut_ctl();
        return {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic drive(input logic v, input logic [5:0] op, input logic [15:0] im,
                         input logic [W-1:0] va, input logic [W-1:0] vb);
        in_valid = v;
        opcode   = op;
        imm      = im;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".ctl"},       64'(dut_ctl()), 64'd0);
        check({tag, ".aluop"},     64'(aluop), 64'd0);
        check({tag, ".aluctl"},    64'(aluctl), 64'd0);
        check({tag, ".result"},    64'(result), 64'd0);
        check({tag, ".zero"},      64'(zero), 64'd0);
    endtask

    task automatic check_vec(input vec_t v, input logic exp_valid);
        check({v.name, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        check({v.name, ".ctl"},       64'(dut_ctl()), 64'(v.ctl));
        check({v.name, ".aluop"},     64'(aluop), 64'(v.aluop));
        check({v.name, ".aluctl"},    64'(aluctl), 64'(v.aluctl));
        check({v.name, ".result"},    64'(result), 64'(v.result));
        check({v.name, ".zero"},      64'(zero), 64'(v.zero));
    endtask

    initial begin
        vecs[0]  = '{"r_add",     6'h00, 16'h0020, 32'd5,        32'd7,        9'b100000100, 2'b10, 4'b0010, 32'd12,       1'b0};
        vecs[1]  = '{"r_slt_neg", 6'h00, 16'h002A, 32'hFFFFFFFF, 32'd1,        9'b100000100, 2'b10, 4'b0111, 32'd1,        1'b0};
        vecs[2]  = '{"r_slt_pos", 6'h00, 16'h002A, 32'd1,        32'hFFFFFFFF, 9'b100000100, 2'b10, 4'b0111, 32'd0,        1'b1};
        vecs[3]  = '{"lw",        6'h23, 16'hFFFC, 32'h100,      32'd0,        9'b000101110, 2'b00, 4'b0010, 32'hFC,       1'b0};
        vecs[4]  = '{"beq",       6'h04, 16'h0000, 32'h1234,     32'h1234,     9'b010000000, 2'b01, 4'b0110, 32'd0,        1'b1};
        vecs[5]  = '{"bne",       6'h05, 16'h0000, 32'd3,        32'd4,        9'b001000000, 2'b01, 4'b0110, 32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{"r_add_wrap",6'h00, 16'h0020, 32'hFFFFFFFF, 32'd1,        9'b100000100, 2'b10, 4'b0010, 32'd0,        1'b1};
        vecs[7]  = '{"op_3f",     6'h3F, 16'h1234, 32'd10,       32'd20,       9'b000000000, 2'b00, 4'b0010, 32'd30,       1'b0};
        vecs[8]  = '{"r_sub",     6'h00, 16'h0022, 32'd10,       32'd3,        9'b100000100, 2'b10, 4'b0110, 32'd7,        1'b0};
        vecs[9]  = '{"r_and",     6'h00, 16'h0024, 32'hF0F0,     32'hFF00,     9'b100000100, 2'b10, 4'b0000, 32'hF000,     1'b0};
        vecs[10] = '{"r_or",      6'h00, 16'h0025, 32'hF0F0,     32'hFF00,     9'b100000100, 2'b10, 4'b0001, 32'hFFF0,     1'b0};
        vecs[11] = '{"r_nor",     6'h00, 16'h0027, 32'd0,        32'd0,        9'b100000100, 2'b10, 4'b1100, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{"r_badfn",   6'h00, 16'h0003, 32'd2,        32'd3,        9'b100000100, 2'b10, 4'b0010, 32'd5,        1'b0};
        vecs[13] = '{"sw",        6'h2B, 16'h0008, 32'h20,       32'h55,       9'b000010010, 2'b00, 4'b0010, 32'h28,       1'b0};
        vecs[14] = '{"addi_neg",  6'h08, 16'h8000, 32'd0,        32'd9,        9'b000000110, 2'b00, 4'b0010, 32'hFFFF8000, 1'b0};
        vecs[15] = '{"j",         6'h02, 16'h0000, 32'd1,        32'd2,        9'b000000001, 2'b00, 4'b0010, 32'd3,        1'b0};

        reset = 1'b1;
        drive(1'b0, 6'h00, 16'h0000, '0, '0);
        drive(1'b0, 6'h00, 16'h0000, '0, '0);
        check_all_zero("reset");
        reset = 1'b0;

        // idle cycle after reset: nothing should emerge
        drive(1'b0, 6'h00, 16'h0020, 32'd5, 32'd7);
        check_all_zero("idle_after_reset");

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].opcode, vecs[i].imm, vecs[i].a, vecs[i].b);
            check_vec(vecs[i], 1'b1);
        end

        // in_valid=0 with different inputs: data must hold the last vector (j)
        drive(1'b0, 6'h00, 16'h0022, 32'd100, 32'd1);
        check_vec(vecs[15], 1'b0);
        drive(1'b0, 6'h23, 16'hFFFC, 32'd7, 32'd7);
        check_vec(vecs[15], 1'b0);

        // back-to-back valids, then reset while a valid is presented
        drive(1'b1, vecs[4].opcode, vecs[4].imm, vecs[4].a, vecs[4].b);
        check_vec(vecs[4], 1'b1);
        reset = 1'b1;
        drive(1'b1, vecs[0].opcode, vecs[0].imm, vecs[0].a, vecs[0].b);
        check_all_zero("reset_with_valid");
        reset = 1'b0;
        drive(1'b0, vecs[0].opcode, vecs[0].imm, vecs[0].a, vecs[0].b);
        check_all_zero("discarded_after_reset");

        // first valid after reset appears exactly one cycle later
        drive(1'b1, vecs[3].opcode, vecs[3].imm, vecs[3].a, vecs[3].b);
        check_vec(vecs[3], 1'b1);
        drive(1'b0, 6'h00, 16'h0000, '0, '0);
        check_vec(vecs[3], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
